// File: rtl/gc_halfgate_engine.sv
// Sequential half-gates garbling engine (free-XOR): one gate in flight, with the
// four hash calls of an AND/OR gate time-multiplexed over one external AES core.
module gc_halfgate_engine #(
  parameter int unsigned  S        = 20,
  parameter int unsigned  K        = 128,
  parameter logic [S-1:0] GID_INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [K-1:0] R,
  input  logic [S-1:0] cid,
  input  logic         gid_clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   gate_type,
  input  logic [K-1:0] in0_label,
  input  logic [K-1:0] in1_label,
  output logic         hash_req_valid,
  input  logic         hash_req_ready,
  output logic [K-1:0] hash_req_data,
  input  logic         hash_rsp_valid,
  input  logic [K-1:0] hash_rsp_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [K-1:0] out_label,
  output logic [K-1:0] t0,
  output logic [K-1:0] t1,
  output logic         out_garbled,
  output logic [S-1:0] out_gid
);

  typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_COMB, ST_OUT} state_t;

  localparam logic [K-1:0] C_POLY = K'(8'h87);

  function automatic logic [K-1:0] f_dbl(input logic [K-1:0] x);
    return {x[K-2:0], 1'b0} ^ (x[K-1] ? C_POLY : '0);
  endfunction

  // Whitened AES input for hash slot idx: 0:A0 1:A1 2:B0 3:B1, tweak sel = idx[1].
  function automatic logic [K-1:0] f_hash_in(input logic [1:0] idx, input logic [K-1:0] a0,
                                             input logic [K-1:0] b0, input logic [K-1:0] r,
                                             input logic [S-1:0] c, input logic [S-1:0] g);
    logic [K-1:0] x;
    logic [K-1:0] t;
    x          = (idx[1] ? b0 : a0) ^ (idx[0] ? r : '0);
    t          = '0;
    t[0]       = idx[1];
    t[S:1]     = g;
    t[2*S:S+1] = c;
    return f_dbl(x) ^ t;
  endfunction

  state_t       r_state, w_next;
  logic [K-1:0] r_R, r_a0, r_b0;
  logic [S-1:0] r_cid, r_gid;
  logic         r_is_or;
  logic [1:0]   r_req_cnt;
  logic [2:0]   r_rsp_cnt;
  logic [K-1:0] r_h [4];
  logic [K-1:0] r_out_label, r_t0, r_t1;
  logic         r_garbled;

  logic         w_accept, w_req_fire, w_out_fire;
  logic [K-1:0] w_req_in, w_rsp_in, w_free_label;
  logic [K-1:0] w_tg, w_wg, w_te, w_we, w_c0;

  assign in_ready       = (r_state == ST_IDLE);
  assign hash_req_valid = (r_state == ST_ISSUE);
  assign out_valid      = (r_state == ST_OUT);
  assign w_accept       = in_valid && in_ready;
  assign w_req_fire     = hash_req_valid && hash_req_ready;
  assign w_out_fire     = out_valid && out_ready;

  assign w_req_in      = f_hash_in(r_req_cnt, r_a0, r_b0, r_R, r_cid, r_gid);
  assign w_rsp_in      = f_hash_in(r_rsp_cnt[1:0], r_a0, r_b0, r_R, r_cid, r_gid);
  assign hash_req_data = hash_req_valid ? w_req_in : '0;
  assign w_free_label  = gate_type[1] ? (in0_label ^ R) : (in0_label ^ in1_label);

  // OR arrives here already as AND on inverted inputs; only the output needs flipping.
  assign w_tg = r_h[0] ^ r_h[1] ^ (r_b0[0] ? r_R : '0);
  assign w_wg = r_h[0] ^ (r_a0[0] ? w_tg : '0);
  assign w_te = r_h[2] ^ r_h[3] ^ r_a0;
  assign w_we = r_h[2] ^ (r_b0[0] ? (w_te ^ r_a0) : '0);
  assign w_c0 = w_wg ^ w_we ^ (r_is_or ? r_R : '0);

  assign out_label   = r_out_label;
  assign t0          = r_t0;
  assign t1          = r_t1;
  assign out_garbled = r_garbled;
  assign out_gid     = r_gid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = gate_type[0] ? ST_ISSUE : ST_OUT;
      ST_ISSUE: if (w_req_fire && (r_req_cnt == 2'd3)) w_next = ST_WAIT;
      ST_WAIT:  if ((r_rsp_cnt == 3'd4) || ((r_rsp_cnt == 3'd3) && hash_rsp_valid))
                  w_next = ST_COMB;
      ST_COMB:  w_next = ST_OUT;
      ST_OUT:   if (w_out_fire) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_R         <= '0;
      r_a0        <= '0;
      r_b0        <= '0;
      r_cid       <= '0;
      r_gid       <= GID_INIT;
      r_is_or     <= 1'b0;
      r_req_cnt   <= '0;
      r_rsp_cnt   <= '0;
      for (int unsigned i = 0; i < 4; i++) r_h[i] <= '0;
      r_out_label <= '0;
      r_t0        <= '0;
      r_t1        <= '0;
      r_garbled   <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && gid_clear) r_gid <= GID_INIT;
      else if (w_out_fire && r_garbled)      r_gid <= r_gid + S'(1);
      if (w_req_fire) r_req_cnt <= r_req_cnt + 2'd1;
      if (hash_rsp_valid) begin
        r_h[r_rsp_cnt[1:0]] <= hash_rsp_data ^ w_rsp_in;
        r_rsp_cnt           <= r_rsp_cnt + 3'd1;
      end
      if (w_accept) begin
        r_R       <= R;
        r_cid     <= cid;
        r_is_or   <= (gate_type == 2'b11);
        r_a0      <= in0_label ^ ((gate_type == 2'b11) ? R : '0);
        r_b0      <= in1_label ^ ((gate_type == 2'b11) ? R : '0);
        r_req_cnt <= '0;
        r_rsp_cnt <= '0;
        if (!gate_type[0]) begin
          r_out_label <= w_free_label;
          r_t0        <= '0;
          r_t1        <= '0;
          r_garbled   <= 1'b0;
        end
      end
      if (r_state == ST_COMB) begin
        r_out_label <= w_c0;
        r_t0        <= w_tg;
        r_t1        <= w_te;
        r_garbled   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gc_halfgate_engine.sv
// Directed bench for gc_halfgate_engine with a latency-configurable AES stub and a
// half-gates reference model including an evaluator-side decode.
module tb_gc_halfgate_engine;
  localparam int unsigned S = 20;
  localparam int unsigned K = 128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [K-1:0] R_in = '0;
  logic [S-1:0] cid_in = '0;
  logic         gid_clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   gate_type = 2'b00;
  logic [K-1:0] in0 = '0;
  logic [K-1:0] in1 = '0;
  logic         hash_req_valid;
  logic         hash_req_ready = 1'b1;
  logic [K-1:0] hash_req_data;
  logic         hash_rsp_valid;
  logic [K-1:0] hash_rsp_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [K-1:0] out_label, t0, t1;
  logic         out_garbled;
  logic [S-1:0] out_gid;

  int n_tests = 0;
  int n_fail  = 0;
  int aes_mode = 0;
  int lat = 1;
  int stall_on = 0;
  int stab_err = 0;
  int stall_seen = 0;
  int hold_err = 0;
  logic [K-1:0] req_log[$];

  gc_halfgate_engine #(.S(S), .K(K), .GID_INIT(20'd0)) dut (
    .clk(clk), .rst_n(rst_n), .R(R_in), .cid(cid_in), .gid_clear(gid_clear),
    .in_valid(in_valid), .in_ready(in_ready), .gate_type(gate_type),
    .in0_label(in0), .in1_label(in1),
    .hash_req_valid(hash_req_valid), .hash_req_ready(hash_req_ready),
    .hash_req_data(hash_req_data), .hash_rsp_valid(hash_rsp_valid),
    .hash_rsp_data(hash_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_label(out_label), .t0(t0), .t1(t1), .out_garbled(out_garbled), .out_gid(out_gid)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [K-1:0] m_dbl(input logic [K-1:0] x);
    logic [K-1:0] r;
    r = {x[K-2:0], 1'b0};
    if (x[K-1]) r[7:0] = r[7:0] ^ 8'h87;
    return r;
  endfunction

  function automatic logic [K-1:0] m_tweak(input logic [S-1:0] c, input logic [S-1:0] g, input logic s);
    return {{(K-2*S-1){1'b0}}, c, g, s};
  endfunction

  function automatic logic [K-1:0] m_aes(input logic [K-1:0] x);
    if (aes_mode == 0) return x;
    return {x[K-14:0], x[K-1:K-13]} ^ 128'h5a5a0f0f_3c3c9696_a5a5f0f0_c3c36969;
  endfunction

  function automatic logic [K-1:0] m_H(input logic [K-1:0] x, input logic s, input logic [S-1:0] g);
    logic [K-1:0] y;
    y = m_dbl(x) ^ m_tweak(cid_in, g, s);
    return m_aes(y) ^ y;
  endfunction

  function automatic logic [K-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic m_garble(input logic [1:0] ty, input logic [K-1:0] a0, input logic [K-1:0] b0,
                          input logic [S-1:0] g, output logic [K-1:0] c0,
                          output logic [K-1:0] tg, output logic [K-1:0] te);
    logic [K-1:0] a, b, ha0, ha1, hb0, hb1, wg, we;
    a = a0; b = b0;
    if (ty == 2'b11) begin a = a ^ R_in; b = b ^ R_in; end
    ha0 = m_H(a, 1'b0, g);  ha1 = m_H(a ^ R_in, 1'b0, g);
    hb0 = m_H(b, 1'b1, g);  hb1 = m_H(b ^ R_in, 1'b1, g);
    tg = ha0 ^ ha1 ^ (b[0] ? R_in : '0);
    wg = ha0 ^ (a[0] ? tg : '0);
    te = hb0 ^ hb1 ^ a;
    we = hb0 ^ (b[0] ? (te ^ a) : '0);
    c0 = wg ^ we;
    if (ty == 2'b11) c0 = c0 ^ R_in;
  endtask

  function automatic logic [K-1:0] m_eval(input logic [K-1:0] wa, input logic [K-1:0] wb,
                                          input logic [K-1:0] tg, input logic [K-1:0] te,
                                          input logic [S-1:0] g);
    return m_H(wa, 1'b0, g) ^ (wa[0] ? tg : '0) ^ m_H(wb, 1'b1, g) ^ (wb[0] ? (te ^ wa) : '0);
  endfunction

  task automatic check(input string tag, input logic [K-1:0] obs, input logic [K-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // AES stub: in-order, fixed latency, cleared by the shared reset.
  typedef struct { logic [K-1:0] d; int due; } pend_t;
  pend_t q[$];
  int    cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cyc = 0;
      hash_rsp_valid <= 1'b0;
      hash_rsp_data  <= '0;
    end else begin
      cyc = cyc + 1;
      hash_rsp_valid <= 1'b0;
      if (q.size() > 0 && q[0].due <= cyc) begin
        hash_rsp_valid <= 1'b1;
        hash_rsp_data  <= m_aes(q[0].d);
        void'(q.pop_front());
      end
      if (hash_req_valid && hash_req_ready) begin
        q.push_back('{hash_req_data, cyc + lat});
        req_log.push_back(hash_req_data);
      end
    end
  end

  logic         prev_stall = 1'b0;
  logic [K-1:0] prev_data = '0;
  always @(posedge clk) begin
    if (prev_stall && (hash_req_data !== prev_data)) stab_err++;
    if (hash_req_valid && !hash_req_ready) stall_seen++;
    prev_stall <= hash_req_valid && !hash_req_ready;
    prev_data  <= hash_req_data;
  end

  always @(negedge clk)
    hash_req_ready = (stall_on != 0) ? 1'($urandom_range(0, 1)) : 1'b1;

  task automatic do_gate(input logic [1:0] ty, input logic [K-1:0] a, input logic [K-1:0] b,
                         input int hold, input logic clr,
                         output logic [K-1:0] lab, output logic [K-1:0] tg, output logic [K-1:0] te,
                         output logic gb, output logic [S-1:0] gd, output int nc);
    @(negedge clk);
    check("in_ready_before_accept", K'(in_ready), K'(1'b1));
    in_valid = 1'b1; gate_type = ty; in0 = a; in1 = b; gid_clear = clr;
    @(negedge clk);
    in_valid = 1'b0; gid_clear = 1'b0;
    nc = 1;
    while (!out_valid && nc < 400) begin
      @(negedge clk);
      nc++;
    end
    check("out_valid_seen", K'(out_valid), K'(1'b1));
    lab = out_label; tg = t0; te = t1; gb = out_garbled; gd = out_gid;
    repeat (hold) begin
      @(negedge clk);
      if (!out_valid || out_label !== lab || t0 !== tg || t1 !== te || out_gid !== gd) hold_err++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic chk_reset();
    check("rst_in_ready", K'(in_ready), K'(1'b1));
    check("rst_req_valid", K'(hash_req_valid), K'(1'b0));
    check("rst_req_data", hash_req_data, '0);
    check("rst_out_valid", K'(out_valid), K'(1'b0));
    check("rst_out_label", out_label, '0);
    check("rst_t0", t0, '0);
    check("rst_t1", t1, '0);
    check("rst_garbled", K'(out_garbled), K'(1'b0));
    check("rst_gid", K'(out_gid), '0);
  endtask

  initial begin
    logic [K-1:0] lab, tg, te, el, et0, et1, a, b, r1l, r1t0, r1t1;
    logic         gb;
    logic [S-1:0] gd;
    int           nc, w;

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset();

    // Free gates
    R_in = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F1;
    req_log.delete();
    do_gate(2'b00, 128'h1, 128'h2, 0, 1'b0, lab, tg, te, gb, gd, nc);
    check("xor_label", lab, 128'h3);
    check("xor_garbled", K'(gb), K'(1'b0));
    check("xor_t0", tg, '0);
    check("xor_t1", te, '0);
    check("xor_latency", K'(nc), K'(1));
    check("xor_gid", K'(gd), '0);
    check("xor_no_hash", K'(req_log.size()), '0);

    R_in = '1;
    do_gate(2'b10, '0, 128'h5, 0, 1'b0, lab, tg, te, gb, gd, nc);
    check("not_label", lab, '1);
    check("not_gid", K'(gd), '0);
    check("not_garbled", K'(gb), K'(1'b0));

    // AND gates, identity AES stub
    cid_in = 20'd1;
    R_in   = 128'hA5A5_1234_5678_9ABC_DEF0_0F0F_3C3C_7777;
    aes_mode = 0;
    do_gate(2'b01, 128'h1, 128'h5, 0, 1'b0, lab, tg, te, gb, gd, nc);
    check("and0_label", lab, R_in);
    check("and0_t0", tg, R_in);
    check("and0_t1", te, 128'h1);
    check("and0_garbled", K'(gb), K'(1'b1));
    check("and0_gid", K'(gd), '0);
    check("and0_latency", K'(nc), K'(8));

    a = rnd128(); b = rnd128();
    do_gate(2'b01, a, b, 0, 1'b0, lab, tg, te, gb, gd, nc);
    m_garble(2'b01, a, b, 20'd1, el, et0, et1);
    check("and1_label", lab, el);
    check("and1_t0", tg, et0);
    check("and1_t1", te, et1);
    check("and1_gid", K'(gd), K'(1));

    b = rnd128();
    req_log.delete();
    do_gate(2'b01, 128'h1, b, 0, 1'b0, lab, tg, te, gb, gd, nc);
    m_garble(2'b01, 128'h1, b, 20'd2, el, et0, et1);
    check("and2_nreq", K'(req_log.size()), K'(4));
    check("and2_req0", req_log[0], 128'h200006);
    check("and2_req2_sel1", req_log[2], m_dbl(b) ^ m_tweak(20'd1, 20'd2, 1'b1));
    check("and2_label", lab, el);
    check("and2_t0", tg, et0);
    check("and2_t1", te, et1);
    check("and2_gid", K'(gd), K'(2));

    aes_mode = 1;
    a = rnd128(); b = rnd128();
    do_gate(2'b01, a, b, 0, 1'b0, lab, tg, te, gb, gd, nc);
    m_garble(2'b01, a, b, 20'd3, el, et0, et1);
    check("and3_gid", K'(gd), K'(3));
    check("and3_label", lab, el);
    check("and3_t0", tg, et0);
    check("and3_t1", te, et1);

    // OR gate with evaluator decode of all four input combinations
    R_in = rnd128(); R_in[0] = 1'b1;
    a = rnd128(); b = rnd128();
    do_gate(2'b11, a, b, 0, 1'b0, lab, tg, te, gb, gd, nc);
    m_garble(2'b11, a, b, 20'd4, el, et0, et1);
    check("or_label", lab, el);
    check("or_t0", tg, et0);
    check("or_t1", te, et1);
    check("or_gid", K'(gd), K'(4));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("or_eval_%0d%0d", i / 2, i % 2),
            m_eval(a ^ ((i / 2 != 0) ? R_in : '0), b ^ ((i % 2 != 0) ? R_in : '0), tg, te, 20'd4),
            lab ^ ((i != 0) ? R_in : '0));
    end

    // Stall run versus no-stall run, gid cleared together with each accept
    a = rnd128(); b = rnd128();
    do_gate(2'b01, a, b, 0, 1'b1, r1l, r1t0, r1t1, gb, gd, nc);
    m_garble(2'b01, a, b, 20'd0, el, et0, et1);
    check("ref_gid_clear", K'(gd), '0);
    check("ref_label", r1l, el);
    lat = 7; stall_on = 1; stab_err = 0; stall_seen = 0; hold_err = 0;
    do_gate(2'b01, a, b, 5, 1'b1, lab, tg, te, gb, gd, nc);
    stall_on = 0; lat = 1;
    check("stall_label", lab, r1l);
    check("stall_t0", tg, r1t0);
    check("stall_t1", te, r1t1);
    check("stall_gid", K'(gd), '0);
    check("stall_req_stable", K'(stab_err), '0);
    check("stall_hold_stable", K'(hold_err), '0);
    check("stall_exercised", K'(stall_seen > 0), K'(1'b1));
    check("stall_model_t1", te, et1);

    // Reset after the second hash request
    req_log.delete();
    @(negedge clk);
    in_valid = 1'b1; gate_type = 2'b01; in0 = rnd128(); in1 = rnd128();
    @(negedge clk);
    in_valid = 1'b0;
    w = 0;
    while (req_log.size() < 2 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("midgate_two_reqs", K'(req_log.size()), K'(2));
    rst_n = 1'b0;
    #1;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_req_valid", K'(hash_req_valid), K'(1'b0));
    check("post_rst_out_valid", K'(out_valid), K'(1'b0));
    do_gate(2'b00, 128'h10, 128'h30, 0, 1'b0, lab, tg, te, gb, gd, nc);
    check("post_rst_xor_label", lab, 128'h20);
    check("post_rst_xor_garbled", K'(gb), K'(1'b0));
    check("post_rst_xor_gid", K'(gd), '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
